// File: rtl/rd_ptr_empty_if.sv
// Read-side FIFO control bundle: read request, synchronized write pointer,
// and the read pointer / address / status flags returned by rd_ptr_empty.
// slave  : the rd_ptr_empty controller.
// master : the logic that issues reads and observes the flags.
interface rd_ptr_empty_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 RINC;
    logic [ADDR_SIZE:0]   RQ2_WPTR;
    logic [ADDR_SIZE:0]   RPTR;
    logic [ADDR_SIZE-1:0] RADDR;
    logic                 REMPTY;
    logic                 RAEMPTY;
    logic [ADDR_SIZE:0]   RCOUNT;
    logic                 RUNDERFLOW;

    modport master (
        output RINC, RQ2_WPTR,
        input  RPTR, RADDR, REMPTY, RAEMPTY, RCOUNT, RUNDERFLOW
    );

    modport slave (
        input  RINC, RQ2_WPTR,
        output RPTR, RADDR, REMPTY, RAEMPTY, RCOUNT, RUNDERFLOW
    );
endinterface

// File: rtl/rd_ptr_empty.sv
// Read-domain pointer and empty-flag controller for the dual-clock FIFO.
// Keeps a binary read pointer (drives the memory read address) and its Gray
// image (sent to the write domain), and derives registered empty, almost-empty,
// occupancy and sticky underflow flags against the synchronized write pointer.
// Optional feature macro: RD_LEVEL_EN -- when defined, the Gray-to-binary
// write-pointer converter, occupancy subtractor and RCOUNT/RAEMPTY registers
// are built; when undefined, RCOUNT is tied to 0 and RAEMPTY mirrors REMPTY.
module rd_ptr_empty #(
    parameter int ADDR_SIZE     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input logic          RCLK,
    input logic          RRST,
    rd_ptr_empty_if.slave bus
);

    // Reject thresholds that cannot be represented by the occupancy count.
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDR_SIZE)) begin : g_bad_thresh
        $error("rd_ptr_empty: AEMPTY_THRESH out of range 0..2^ADDR_SIZE");
    end

    logic [ADDR_SIZE:0] rd_bin;
    logic [ADDR_SIZE:0] rd_binnext;
    logic [ADDR_SIZE:0] rd_graynext;
    logic [ADDR_SIZE:0] rptr_q;
    logic               rempty_q;
    logic               raempty_q;
    logic               runderflow_q;
    logic               accept;
    logic               rempty_next;
    logic               raempty_next;

    // Next read pointer in binary and Gray, plus the next empty decision.
    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment) so no latch can be inferred.
    always_comb begin
        accept      = bus.RINC & ~rempty_q;
        rd_binnext  = rd_bin + {{ADDR_SIZE{1'b0}}, accept};
        rd_graynext = (rd_binnext >> 1) ^ rd_binnext;
        // Full-width compare: the wrap bit separates empty from full.
        rempty_next = (rd_graynext == bus.RQ2_WPTR);
    end

`ifdef RD_LEVEL_EN
    localparam logic [ADDR_SIZE:0] AEMPTY_THRESH_W = AEMPTY_THRESH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] rcount_next;
    logic [ADDR_SIZE:0] rcount_q;

    // Gray-to-binary of the synchronized write pointer, then next occupancy.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            // Each binary bit is the XOR of its Gray bit and all bits above it.
            wbin[i] = ^(bus.RQ2_WPTR >> i);
        end
        rcount_next  = wbin - rd_binnext;
        raempty_next = (rcount_next <= AEMPTY_THRESH_W);
    end

    // Occupancy register; cleared to zero by reset.
    always_ff @(posedge RCLK) begin
        if (RRST) begin
            rcount_q <= '0;
        end else begin
            rcount_q <= rcount_next;
        end
    end

    assign bus.RCOUNT = rcount_q;
`else
    // Without level tracking, almost-empty degenerates to a copy of empty.
    always_comb begin
        raempty_next = rempty_next;
    end

    assign bus.RCOUNT = '0;
`endif

    // Pointer and flag state; reset has priority over any read request.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and ordering between blocks is moot.
    always_ff @(posedge RCLK) begin
        if (RRST) begin
            rd_bin       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rd_bin       <= rd_binnext;
            rptr_q       <= rd_graynext;
            rempty_q     <= rempty_next;
            raempty_q    <= raempty_next;
            runderflow_q <= runderflow_q | (bus.RINC & rempty_q);
        end
    end

    assign bus.RPTR       = rptr_q;
    assign bus.RADDR      = rd_bin[ADDR_SIZE-1:0];
    assign bus.REMPTY     = rempty_q;
    assign bus.RAEMPTY    = raempty_q;
    assign bus.RUNDERFLOW = runderflow_q;

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Directed bench for rd_ptr_empty (ADDR_SIZE=4, AEMPTY_THRESH=2): reset,
// fill-then-drain, underflow, full occupancy and pointer wrap. Expected
// RCOUNT/RAEMPTY follow the build (RD_LEVEL_EN defined or not).
module tb_rd_ptr_empty;

    localparam int ADDR_SIZE     = 4;
    localparam int AEMPTY_THRESH = 2;
`ifdef RD_LEVEL_EN
    localparam bit LEVEL_EN = 1'b1;
`else
    localparam bit LEVEL_EN = 1'b0;
`endif

    logic RCLK;
    logic RRST;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    rd_ptr_empty_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

    rd_ptr_empty #(
        .ADDR_SIZE    (ADDR_SIZE),
        .AEMPTY_THRESH(AEMPTY_THRESH)
    ) dut (
        .RCLK(RCLK),
        .RRST(RRST),
        .bus (bus)
    );

    initial RCLK = 1'b0;
    always #5 RCLK = ~RCLK;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge RCLK);
        #1;
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = b[4:0];
        return (v >> 1) ^ v;
    endfunction

    function automatic logic [4:0] exp_cnt(input int n);
        return LEVEL_EN ? n[4:0] : 5'd0;
    endfunction

    function automatic logic exp_ae(input int n, input logic empty);
        return LEVEL_EN ? (n <= AEMPTY_THRESH) : empty;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;

        // Reset held 2 edges with a read request and a non-zero write pointer.
        RRST         = 1'b1;
        bus.RINC     = 1'b1;
        bus.RQ2_WPTR = 5'b00010;
        step();
        step();
        check("rst_rptr",   32'(bus.RPTR),       32'h0);
        check("rst_raddr",  32'(bus.RADDR),      32'h0);
        check("rst_rempty", 32'(bus.REMPTY),     32'h1);
        check("rst_raempty",32'(bus.RAEMPTY),    32'h1);
        check("rst_rcount", 32'(bus.RCOUNT),     32'h0);
        check("rst_runder", 32'(bus.RUNDERFLOW), 32'h0);

        // Fill: write pointer shows 3 entries, no read.
        RRST     = 1'b0;
        bus.RINC = 1'b0;
        step();
        check("fill_rempty", 32'(bus.REMPTY),  32'h0);
        check("fill_rcount", 32'(bus.RCOUNT),  32'(exp_cnt(3)));
        check("fill_raempty",32'(bus.RAEMPTY), 32'(exp_ae(3, 1'b0)));

        // Drain three entries.
        bus.RINC = 1'b1;
        step();
        check("drain1_raddr",  32'(bus.RADDR),   32'h1);
        check("drain1_rptr",   32'(bus.RPTR),    32'h01);
        check("drain1_rcount", 32'(bus.RCOUNT),  32'(exp_cnt(2)));
        check("drain1_raempty",32'(bus.RAEMPTY), 32'(exp_ae(2, 1'b0)));
        check("drain1_rempty", 32'(bus.REMPTY),  32'h0);
        step();
        check("drain2_raddr",  32'(bus.RADDR),   32'h2);
        check("drain2_rptr",   32'(bus.RPTR),    32'h03);
        check("drain2_rcount", 32'(bus.RCOUNT),  32'(exp_cnt(1)));
        check("drain2_raempty",32'(bus.RAEMPTY), 32'(exp_ae(1, 1'b0)));
        check("drain2_rempty", 32'(bus.REMPTY),  32'h0);
        step();
        check("drain3_raddr",  32'(bus.RADDR),   32'h3);
        check("drain3_rptr",   32'(bus.RPTR),    32'h02);
        check("drain3_rcount", 32'(bus.RCOUNT),  32'h0);
        check("drain3_raempty",32'(bus.RAEMPTY), 32'h1);
        check("drain3_rempty", 32'(bus.REMPTY),  32'h1);
        check("drain3_runder", 32'(bus.RUNDERFLOW), 32'h0);

        // Underflow: read while empty is ignored and sets the sticky flag.
        step();
        check("uf_raddr", 32'(bus.RADDR),      32'h3);
        check("uf_rptr",  32'(bus.RPTR),       32'h02);
        check("uf_flag",  32'(bus.RUNDERFLOW), 32'h1);
        bus.RINC = 1'b0;
        step();
        check("uf_sticky",32'(bus.RUNDERFLOW), 32'h1);
        check("uf_rempty",32'(bus.REMPTY),     32'h1);

        // Reset mid-sequence clears the sticky flag and the pointer.
        RRST         = 1'b1;
        bus.RQ2_WPTR = 5'b11000;
        step();
        check("rst2_runder", 32'(bus.RUNDERFLOW), 32'h0);
        check("rst2_rptr",   32'(bus.RPTR),       32'h0);
        check("rst2_raddr",  32'(bus.RADDR),      32'h0);
        check("rst2_rempty", 32'(bus.REMPTY),     32'h1);

        // Full occupancy: write pointer gray(16) against read pointer 0.
        RRST = 1'b0;
        step();
        check("full_rcount", 32'(bus.RCOUNT),  32'(exp_cnt(16)));
        check("full_rempty", 32'(bus.REMPTY),  32'h0);
        check("full_raempty",32'(bus.RAEMPTY), 32'h0);

        // Wrap: return to empty at pointer 0, then one write/one read per step.
        RRST         = 1'b1;
        bus.RQ2_WPTR = 5'b00000;
        step();
        RRST = 1'b0;
        step();
        check("wrap_start_rempty", 32'(bus.REMPTY), 32'h1);
        for (int k = 1; k <= 32; k++) begin
            bus.RQ2_WPTR = gray5(k);
            bus.RINC     = 1'b0;
            step();
            check("wrap_vis_rempty", 32'(bus.REMPTY),  32'h0);
            check("wrap_vis_rcount", 32'(bus.RCOUNT),  32'(exp_cnt(1)));
            check("wrap_vis_raempty",32'(bus.RAEMPTY), 32'(exp_ae(1, 1'b0)));
            bus.RINC = 1'b1;
            step();
            check("wrap_raddr",  32'(bus.RADDR),  32'(k % 16));
            check("wrap_rptr",   32'(bus.RPTR),   32'(gray5(k)));
            check("wrap_rempty", 32'(bus.REMPTY), 32'h1);
        end
        check("wrap_end_rptr",   32'(bus.RPTR),       32'h0);
        check("wrap_end_runder", 32'(bus.RUNDERFLOW), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
